seq_mult_control: RTL and testbench

SEQ_MULT_CONTROL -- requirements
Module: seq_mult_control

---
 rtl/mult_pkg.sv | 29 ++
 rtl/mult_iter_counter.sv | 34 +++
 rtl/seq_mult_control.sv | 127 ++++++++++++
 tb/tb_seq_mult_control.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared encodings for the sequential shift-add multiplier controller:
// register shift codes, product source select and the FSM state enum.
package mult_pkg;

    // Shift codes for the multiplicand and multiplier registers.
    // 2'b11 is never driven by the controller.
    localparam logic [1:0] SHIFT_NONE  = 2'b00;
    localparam logic [1:0] SHIFT_RIGHT = 2'b01;
    localparam logic [1:0] SHIFT_LEFT  = 2'b10;

    // Product register source select.
    localparam logic PROD_SEL_ZERO = 1'b0;
    localparam logic PROD_SEL_SUM  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Width of the iteration counter; at least one bit even for tiny WIDTH.
    function automatic int iter_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the shift-add loop. Counts completed SHIFT steps,
// raises 'last' when WIDTH-1 steps have been counted, and saturates there
// so it never wraps inside one operation.
module mult_iter_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic incr,
    output logic last
);

    localparam int CNT_W = iter_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;

    assign last = (count == LAST_CNT);

    // Clear on operation start, step once per SHIFT, hold at the last count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && !last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_mult_control.sv
// Control FSM for a sequential shift-add multiplier. Moore machine with
// registered outputs: every output is decoded from the state being entered,
// so it is valid for the whole cycle the FSM spends in that state.
//
// Optional feature: define EARLY_TERM_EN to let TEST finish the operation as
// soon as the multiplier register reaches zero (takes priority over the lsb).
module seq_mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       mplier_lsb,
    input  logic       mplier_zero,
    output logic       mcand_wr,
    output logic [1:0] mcand_shift,
    output logic       mplier_wr,
    output logic [1:0] mplier_shift,
    output logic       prod_wr,
    output logic       prod_sel,
    output logic       busy,
    output logic       done
);

    state_t state;
    logic   cnt_last;
    logic   early_term;

`ifdef EARLY_TERM_EN
    assign early_term = mplier_zero;
`else
    logic unused_mplier_zero;
    assign unused_mplier_zero = mplier_zero;
    assign early_term         = 1'b0;
`endif

    mult_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == ST_LOAD),
        .incr    (state == ST_SHIFT),
        .last    (cnt_last)
    );

    // State transitions with outputs registered for the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mcand_wr     <= 1'b0;
            mcand_shift  <= SHIFT_NONE;
            mplier_wr    <= 1'b0;
            mplier_shift <= SHIFT_NONE;
            prod_wr      <= 1'b0;
            prod_sel     <= PROD_SEL_ZERO;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            mcand_wr     <= 1'b0;
            mcand_shift  <= SHIFT_NONE;
            mplier_wr    <= 1'b0;
            mplier_shift <= SHIFT_NONE;
            prod_wr      <= 1'b0;
            prod_sel     <= PROD_SEL_ZERO;
            busy         <= 1'b1;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        mcand_wr  <= 1'b1;
                        mplier_wr <= 1'b1;
                        prod_wr   <= 1'b1;
                        prod_sel  <= PROD_SEL_ZERO;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_TEST;
                end
                ST_TEST: begin
                    if (early_term) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (mplier_lsb) begin
                        state    <= ST_ADD;
                        prod_wr  <= 1'b1;
                        prod_sel <= PROD_SEL_SUM;
                    end else begin
                        state        <= ST_SHIFT;
                        mcand_shift  <= SHIFT_LEFT;
                        mplier_shift <= SHIFT_RIGHT;
                    end
                end
                ST_ADD: begin
                    state        <= ST_SHIFT;
                    mcand_shift  <= SHIFT_LEFT;
                    mplier_shift <= SHIFT_RIGHT;
                end
                ST_SHIFT: begin
                    // Counter still shows the pre-increment value here.
                    if (cnt_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_TEST;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at: one IDLE cycle
                    // always separates operations.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_control.sv
// Directed bench for seq_mult_control at WIDTH=4 with a behavioural
// shift-add datapath attached. Cycle 0 is the edge that samples start;
// cycle N is observed on the falling edge after rising edge N-1.
module tb_seq_mult_control;

    localparam int W = 4;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       mplier_lsb;
    logic       mplier_zero;
    logic       mcand_wr;
    logic [1:0] mcand_shift;
    logic       mplier_wr;
    logic [1:0] mplier_shift;
    logic       prod_wr;
    logic       prod_sel;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;
    int illegal_cnt;

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] dp_mcand;
    logic [W-1:0]   dp_mplier;
    logic [2*W-1:0] dp_prod;
    logic [9:0]     outs;

    seq_mult_control #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .mplier_lsb   (mplier_lsb),
        .mplier_zero  (mplier_zero),
        .mcand_wr     (mcand_wr),
        .mcand_shift  (mcand_shift),
        .mplier_wr    (mplier_wr),
        .mplier_shift (mplier_shift),
        .prod_wr      (prod_wr),
        .prod_sel     (prod_sel),
        .busy         (busy),
        .done         (done)
    );

    assign outs = {mcand_wr, mcand_shift, mplier_wr, mplier_shift,
                   prod_wr, prod_sel, busy, done};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural datapath driven by the controller
    assign mplier_lsb  = dp_mplier[0];
    assign mplier_zero = (dp_mplier == '0);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dp_mcand  <= '0;
            dp_mplier <= '0;
            dp_prod   <= '0;
        end else begin
            if (mcand_wr)                dp_mcand <= {{W{1'b0}}, op_a};
            else if (mcand_shift == 2'b10) dp_mcand <= dp_mcand << 1;
            else if (mcand_shift == 2'b01) dp_mcand <= dp_mcand >> 1;
            if (mplier_wr)                dp_mplier <= op_b;
            else if (mplier_shift == 2'b01) dp_mplier <= dp_mplier >> 1;
            else if (mplier_shift == 2'b10) dp_mplier <= dp_mplier << 1;
            if (prod_wr) dp_prod <= prod_sel ? (dp_prod + dp_mcand) : '0;
        end
    end

    // Tally any reserved shift code seen on either register
    always @(negedge clock) begin
        if (mcand_shift == 2'b11 || mplier_shift == 2'b11) illegal_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        start   = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Launch one operation and record what the controller did until done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int done_cyc, output int adds,
                          output int shifts, output logic [63:0] pw_mask);
        op_a = a;
        op_b = b;
        done_cyc = -1;
        adds = 0;
        shifts = 0;
        pw_mask = '0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
            @(negedge clock);
            if (prod_wr && c < 64) pw_mask[c] = 1'b1;
            if (prod_wr && prod_sel) adds++;
            if (mplier_shift == 2'b01) shifts++;
            if (done) done_cyc = c;
        end
    endtask

    task automatic test_reset();
        start   = 1'b0;
        op_a    = 4'd3;
        op_b    = 4'd0;
        reset_n = 1'b0;
        #12;
        n_vec++;
        if (outs !== 10'd0) begin
            n_err++; $display("FAIL reset_outs: got %b expected %b", outs, 10'd0);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (outs !== 10'd0) begin
            n_err++; $display("FAIL reset_held_outs: got %b expected %b", outs, 10'd0);
        end
        @(negedge clock);
        start   = 1'b1;
        reset_n = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({mcand_wr, mplier_wr, prod_wr, prod_sel} !== 4'b1110) begin
            n_err++; $display("FAIL reset_first_load: got %b expected 1110",
                              {mcand_wr, mplier_wr, prod_wr, prod_sel});
        end
        n_vec++;
        if ({busy, done, mcand_shift, mplier_shift} !== 6'b100000) begin
            n_err++; $display("FAIL reset_first_load_misc: got %b expected 100000",
                              {busy, done, mcand_shift, mplier_shift});
        end
        apply_reset();
    endtask

    task automatic test_zero_mult();
        int d, a, s;
        logic [63:0] pw;
        int exp_d, exp_s;
`ifdef EARLY_TERM_EN
        exp_d = 3;  exp_s = 0;
`else
        exp_d = 10; exp_s = 4;
`endif
        run_op(4'd7, 4'b0000, d, a, s, pw);
        n_vec++;
        if (d !== exp_d) begin
            n_err++; $display("FAIL zero_done_cycle: got %0d expected %0d", d, exp_d);
        end
        n_vec++;
        if (pw !== 64'h2) begin
            n_err++; $display("FAIL zero_prod_wr_cycles: got %h expected %h", pw, 64'h2);
        end
        n_vec++;
        if (s !== exp_s) begin
            n_err++; $display("FAIL zero_shift_count: got %0d expected %0d", s, exp_s);
        end
        n_vec++;
        if (dp_prod !== 8'd0) begin
            n_err++; $display("FAIL zero_product: got %0d expected 0", dp_prod);
        end
    endtask

    task automatic test_mult_1011();
        int d, a, s;
        logic [63:0] pw;
        run_op(4'd13, 4'b1011, d, a, s, pw);
        n_vec++;
        if (d !== 13) begin
            n_err++; $display("FAIL m1011_done_cycle: got %0d expected 13", d);
        end
        n_vec++;
        if (a !== 3) begin
            n_err++; $display("FAIL m1011_add_count: got %0d expected 3", a);
        end
        n_vec++;
        if (s !== 4) begin
            n_err++; $display("FAIL m1011_shift_count: got %0d expected 4", s);
        end
        n_vec++;
        if (dp_prod !== 8'd143) begin
            n_err++; $display("FAIL m1011_product: got %0d expected 143", dp_prod);
        end
    endtask

    task automatic test_start_ignore();
        int loads_mid;
        logic done10, busy11, ld12;
        int done2;
        loads_mid = 0;
        done10 = 1'b0;
        busy11 = 1'b1;
        ld12   = 1'b0;
        done2  = -1;
        op_a = 4'd2;
`ifdef EARLY_TERM_EN
        op_b = 4'b0100;
`else
        op_b = 4'b0000;
`endif
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 40 && done2 < 0; c++) begin
            @(negedge clock);
            if (c >= 2 && c <= 11 && mcand_wr) loads_mid++;
            if (c == 10) done10 = done;
            if (c == 11) busy11 = busy;
            if (c == 12) ld12 = mcand_wr;
            if (c > 12 && done) done2 = c;
            start = (c == 3 || c == 10 || c == 11);
        end
        start = 1'b0;
        n_vec++;
        if (done10 !== 1'b1) begin
            n_err++; $display("FAIL ignore_first_done: got %b expected 1", done10);
        end
        n_vec++;
        if (loads_mid !== 0) begin
            n_err++; $display("FAIL ignore_no_reload: got %0d expected 0", loads_mid);
        end
        n_vec++;
        if (busy11 !== 1'b0) begin
            n_err++; $display("FAIL ignore_idle_gap: got busy=%b expected 0", busy11);
        end
        n_vec++;
        if (ld12 !== 1'b1) begin
            n_err++; $display("FAIL ignore_held_accept: got %b expected 1", ld12);
        end
        n_vec++;
        if (done2 !== 21) begin
            n_err++; $display("FAIL ignore_second_done: got %0d expected 21", done2);
        end
        n_vec++;
        if (illegal_cnt !== 0) begin
            n_err++; $display("FAIL illegal_shift_code: got %0d expected 0", illegal_cnt);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic found;
        int d, a, s;
        logic [63:0] pw;
        found = 1'b0;
        op_a = 4'd13;
        op_b = 4'b1011;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(negedge clock);
            if (mcand_shift == 2'b10) found = 1'b1;
        end
        n_vec++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL midreset_reach_shift: got %b expected 1", found);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (outs !== 10'd0) begin
            n_err++; $display("FAIL midreset_outs: got %b expected %b", outs, 10'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        run_op(4'd13, 4'b1011, d, a, s, pw);
        n_vec++;
        if (d !== 13) begin
            n_err++; $display("FAIL midreset_rerun_done: got %0d expected 13", d);
        end
        n_vec++;
        if (dp_prod !== 8'd143) begin
            n_err++; $display("FAIL midreset_rerun_product: got %0d expected 143", dp_prod);
        end
    endtask

    task automatic test_early_term();
        int d, a, s;
        logic [63:0] pw;
        int exp_d;
`ifdef EARLY_TERM_EN
        exp_d = 8;
`else
        exp_d = 11;
`endif
        run_op(4'd5, 4'b0010, d, a, s, pw);
        n_vec++;
        if (d !== exp_d) begin
            n_err++; $display("FAIL early_done_cycle: got %0d expected %0d", d, exp_d);
        end
        n_vec++;
        if (dp_prod !== 8'd10) begin
            n_err++; $display("FAIL early_product: got %0d expected 10", dp_prod);
        end
        n_vec++;
        if (a !== 1) begin
            n_err++; $display("FAIL early_add_count: got %0d expected 1", a);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        illegal_cnt = 0;
        start = 1'b0;
        reset_n = 1'b0;
        op_a = '0;
        op_b = '0;
        test_reset();
        test_zero_mult();
        test_mult_1011();
        test_start_ignore();
        test_reset_mid_shift();
        test_early_term();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
